// File: rtl/axi4_mem_pkg.sv
// Shared types and helpers for the AXI4 memory bank and its response FIFO.
package axi4_mem_pkg;

  localparam int RSP_DATA_WIDTH = 32;
  localparam int STRB_WIDTH     = RSP_DATA_WIDTH / 8;
  localparam int LANE_WIDTH     = RSP_DATA_WIDTH / STRB_WIDTH;

  typedef struct packed {
    logic [RSP_DATA_WIDTH-1:0] rdata;
    logic                      is_write;
    logic                      err;
  } rsp_t;

  // Ceiling log2, never less than 1 so it can size pointers for depth 1.
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 1) ? value - 1 : 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_mem_rsp_fifo.sv
// Show-ahead response FIFO; push and pop may coincide, including when full.
module axi4_mem_rsp_fifo
  import axi4_mem_pkg::*;
#(
  parameter int WIDTH = $bits(rsp_t),
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (cnt == CNT_W'(DEPTH));
    empty    = (cnt == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = store[rd_ptr];
    count    = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/axi4_mem_bank.sv
// Single-port memory bank with valid/ready requests, byte strobes, configurable
// read latency, range errors and a credit-limited in-order response channel.
module axi4_mem_bank
  import axi4_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_is_write,
  output logic                    rsp_err
);

  localparam int STRB_W = DATA_WIDTH / LANE_WIDTH;
  localparam int IDX_W  = clog2(DEPTH);
  localparam int OUT_W  = clog2(RSP_FIFO_DEPTH + 1);
  localparam int RSP_W  = DATA_WIDTH + 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  is_write;
    logic                  err;
  } bank_rsp_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             pop;
  logic [OUT_W-1:0] outstanding;
  bank_rsp_t        s0;
  logic             push;
  bank_rsp_t        push_rsp;

  always_comb begin
    req_ready = (outstanding < OUT_W'(RSP_FIFO_DEPTH));
    accept    = req_valid && req_ready;
    in_range  = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
    idx       = req_addr[IDX_W-1:0];
    pop       = rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (req_wstrb[i]) mem[idx][LANE_WIDTH*i +: LANE_WIDTH] <= req_wdata[LANE_WIDTH*i +: LANE_WIDTH];
      end
    end
  end

  // Stage 0 reads the array combinationally so the value present at the accept
  // edge is what travels down the pipe; the FIFO register is the last stage.
  always_comb begin
    s0          = '0;
    s0.is_write = req_we;
    s0.err      = !in_range;
    if (in_range && !req_we) s0.rdata = mem[idx];
  end

  if (READ_LATENCY > 1) begin : g_pipe
    localparam int STAGES = READ_LATENCY - 1;
    logic      pv [STAGES];
    bank_rsp_t pd [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          pv[k] <= 1'b0;
          pd[k] <= '0;
        end
      end else begin
        pv[0] <= accept;
        pd[0] <= s0;
        for (int unsigned k = 1; k < STAGES; k++) begin
          pv[k] <= pv[k-1];
          pd[k] <= pd[k-1];
        end
      end
    end

    always_comb begin
      push     = pv[STAGES-1];
      push_rsp = pd[STAGES-1];
    end
  end else begin : g_nopipe
    always_comb begin
      push     = accept;
      push_rsp = s0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  logic [RSP_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_count;
  bank_rsp_t        head;

  axi4_mem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    head         = fifo_head;
    rsp_valid    = !fifo_empty;
    rsp_rdata    = rsp_valid ? head.rdata : '0;
    rsp_is_write = rsp_valid && head.is_write;
    rsp_err      = rsp_valid && head.err;
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                   outstanding <= OUT_W'(RSP_FIFO_DEPTH));
  a_fifo_within:  assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= outstanding);
  a_full_push:    assert property (@(posedge clk) disable iff (!rst_n) fifo_full && push |-> pop);

endmodule
